// File: rtl/br_pkg.sv
// Shared types and constants for the BR write-port arbiter.
// Entry layout {addr, data} used by the write FIFO.
package br_pkg;

  localparam int AW_DEF = 5;
  localparam int DW_DEF = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] data;
  } br_entry_t;

endpackage

// File: rtl/br_wfifo.sv
// Synchronous FIFO for long-latency writes with count, head outputs
// and per-entry addr/valid taps. Ports: push/pop side, count, taps.
module br_wfifo
  import br_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [AW-1:0]             push_addr,
  input  logic [DW-1:0]             push_data,
  input  logic                      pop,
  output logic [CW-1:0]             count,
  output logic [AW-1:0]             head_addr,
  output logic [DW-1:0]             head_data,
  output logic [DEPTH-1:0][AW-1:0]  ent_addr,
  output logic [DEPTH-1:0]          ent_vld
);

  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0]    addr_q [DEPTH];
  logic [AW-1:0]    addr_d [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DW-1:0]    data_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    vld_d   = vld_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    if (pop) begin
      vld_d[rptr_q] = 1'b0;
      rptr_d        = rptr_q + 1'b1;
    end
    if (push) begin
      addr_d[wptr_q] = push_addr;
      data_d[wptr_q] = push_data;
      vld_d[wptr_q]  = 1'b1;
      wptr_d         = wptr_q + 1'b1;
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q   <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      vld_q   <= vld_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: vld_q qualifies every slot.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_addr[i] = addr_q[i];
    end
  end

  assign ent_vld   = vld_q;
  assign count     = count_q;
  assign head_addr = addr_q[rptr_q];
  assign head_data = data_q[rptr_q];

endmodule

// File: rtl/br_write_arbiter.sv
// Arbitrates the BR write port between WB (fixed priority) and a
// buffered long-latency unit; drives hazard stall and bubble request.
module br_write_arbiter
  import br_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4,
  parameter int DW       = DW_DEF,
  parameter int AW       = AW_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wb_we,
  input  logic [AW-1:0]              wb_addr,
  input  logic [DW-1:0]              wb_data,
  input  logic                       mu_valid,
  output logic                       mu_ready,
  input  logic [AW-1:0]              mu_addr,
  input  logic [DW-1:0]              mu_data,
  input  logic [AW-1:0]              rs,
  input  logic [AW-1:0]              rt,
  input  logic [AW-1:0]              dest_sel,
  output logic                       RegWrite,
  output logic [AW-1:0]              WriteReg,
  output logic [DW-1:0]              WriteData,
  output logic                       hazard_stall,
  output logic                       bubble_req,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [AW-1:0] ZERO = AW'(REG_ZERO);

  logic [CW-1:0]            count;
  logic [AW-1:0]            head_addr;
  logic [DW-1:0]            head_data;
  logic [DEPTH-1:0][AW-1:0] ent_addr;
  logic [DEPTH-1:0]         ent_vld;

  logic wb_busy, has_entry;
  logic accept, push, pop;
  logic [WW-1:0] wait_q, wait_d;
  logic hit_rs, hit_rt, hit_ds;

  assign wb_busy   = wb_we && (wb_addr != ZERO);
  assign has_entry = (count != '0);
  assign mu_ready  = rst_n && (count < CW'(DEPTH));
  assign accept    = mu_valid && mu_ready;
  // Writes to r0 are acknowledged but never stored.
  assign push      = accept && (mu_addr != ZERO);
  assign pop       = rst_n && !wb_busy && has_entry;

  br_wfifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW),
    .CW    (CW)
  ) u_wfifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_addr (mu_addr),
    .push_data (mu_data),
    .pop       (pop),
    .count     (count),
    .head_addr (head_addr),
    .head_data (head_data),
    .ent_addr  (ent_addr),
    .ent_vld   (ent_vld)
  );

  always_comb begin
    RegWrite  = 1'b0;
    WriteReg  = '0;
    WriteData = '0;
    if (rst_n && wb_busy) begin
      RegWrite  = 1'b1;
      WriteReg  = wb_addr;
      WriteData = wb_data;
    end else if (rst_n && has_entry) begin
      RegWrite  = 1'b1;
      WriteReg  = head_addr;
      WriteData = head_data;
    end
  end

  always_comb begin
    wait_d = wait_q;
    if (pop || !has_entry) begin
      wait_d = '0;
    end else if (wb_busy && wait_q != WW'(MAX_WAIT)) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end

  assign bubble_req = rst_n && (wait_q == WW'(MAX_WAIT));

  // Match decode sources against every pending or incoming write.
  always_comb begin
    hit_rs = accept && (mu_addr == rs);
    hit_rt = accept && (mu_addr == rt);
    hit_ds = accept && (mu_addr == dest_sel);
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && ent_addr[i] == rs)       hit_rs = 1'b1;
      if (ent_vld[i] && ent_addr[i] == rt)       hit_rt = 1'b1;
      if (ent_vld[i] && ent_addr[i] == dest_sel) hit_ds = 1'b1;
    end
    hit_rs = hit_rs && (rs != ZERO);
    hit_rt = hit_rt && (rt != ZERO);
    hit_ds = hit_ds && (dest_sel != ZERO);
  end

  assign hazard_stall = rst_n && (hit_rs || hit_rt || hit_ds);
  assign fifo_count   = count;

endmodule

// File: tb/tb_br_write_arbiter.sv
// Scoreboard bench for br_write_arbiter: stimulus queues expected BR
// writes, a negedge monitor pops and compares them.
module tb_br_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        mu_valid = 1'b0;
  logic        mu_ready;
  logic [4:0]  mu_addr = '0;
  logic [31:0] mu_data = '0;
  logic [4:0]  rs = '0;
  logic [4:0]  rt = '0;
  logic [4:0]  dest_sel = '0;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic        hazard_stall;
  logic        bubble_req;
  logic [1:0]  fifo_count;

  br_write_arbiter #(
    .DEPTH    (2),
    .MAX_WAIT (4),
    .DW       (32),
    .AW       (5)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wb_we        (wb_we),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .mu_valid     (mu_valid),
    .mu_ready     (mu_ready),
    .mu_addr      (mu_addr),
    .mu_data      (mu_data),
    .rs           (rs),
    .rt           (rt),
    .dest_sel     (dest_sel),
    .RegWrite     (RegWrite),
    .WriteReg     (WriteReg),
    .WriteData    (WriteData),
    .hazard_stall (hazard_stall),
    .bubble_req   (bubble_req),
    .fifo_count   (fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mq[$];
  int  n_chk = 0;
  int  n_fail = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h @%0t",
               name, act, req, $time);
    end
  endtask

  // Monitor: one expected write at most is queued per cycle.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (RegWrite === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {31'd0, RegWrite}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", {27'd0, WriteReg}, {27'd0, e.a});
          check("write_data", WriteData, e.d);
        end
      end else if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("missing_write", {31'd0, RegWrite}, 32'd1);
      end
    end
  end

  // Drive one cycle and advance the reference FIFO model.
  task automatic cyc(input logic r, input logic we,
                     input logic [4:0] wa, input logic [31:0] wd,
                     input logic mv, input logic [4:0] ma,
                     input logic [31:0] md);
    logic rdy;
    @(posedge clk);
    #1;
    rst_n = r; wb_we = we; wb_addr = wa; wb_data = wd;
    mu_valid = mv; mu_addr = ma; mu_data = md;
    #1;
    rdy = r && (mq.size() < 2);
    check("fifo_count", {30'd0, fifo_count}, mq.size());
    check("mu_ready", {31'd0, mu_ready}, {31'd0, rdy});
    if (!r) begin
      mq.delete();
    end else begin
      if (we && wa != 5'd0) exp_q.push_back('{wa, wd});
      else if (mq.size() != 0) exp_q.push_back(mq.pop_front());
      if (mv && rdy && ma != 5'd0) mq.push_back('{ma, md});
    end
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    // 1: reset with activity on both requesters
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 5'd5, 32'h11, 1'b1, 5'd7, 32'h22);
      rs = 5'd7;
      #1;
      check("rst_regwrite", {31'd0, RegWrite}, 32'd0);
      check("rst_hazard", {31'd0, hazard_stall}, 32'd0);
      check("rst_bubble", {31'd0, bubble_req}, 32'd0);
      rs = 5'd0;
    end
    idle();
    check("rel_ready", {31'd0, mu_ready}, 32'd1);

    // 2: single long-latency write, no bypass
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'hCAFE0001);
    check("nobypass", {31'd0, RegWrite}, 32'd0);
    idle();
    check("mu_wr_reg", {27'd0, WriteReg}, 32'd8);
    check("mu_wr_data", WriteData, 32'hCAFE0001);
    idle();
    check("drained", {30'd0, fifo_count}, 32'd0);

    // 3: WB wins, FIFO order 9 then 10
    cyc(1'b1, 1'b1, 5'd3, 32'hA3, 1'b1, 5'd9, 32'h9999);
    check("wb_prio3", {27'd0, WriteReg}, 32'd3);
    cyc(1'b1, 1'b1, 5'd4, 32'hA4, 1'b1, 5'd10, 32'h1010);
    check("wb_prio4", {27'd0, WriteReg}, 32'd4);
    idle();
    check("order_9", {27'd0, WriteReg}, 32'd9);
    idle();
    check("order_10", {27'd0, WriteReg}, 32'd10);
    idle();

    // 4: full FIFO and starvation bubble
    cyc(1'b1, 1'b1, 5'd1, 32'hB1, 1'b1, 5'd13, 32'hD13);
    cyc(1'b1, 1'b1, 5'd2, 32'hB2, 1'b1, 5'd14, 32'hD14);
    check("bub_b", {31'd0, bubble_req}, 32'd0);
    cyc(1'b1, 1'b1, 5'd1, 32'hB3, 1'b1, 5'd15, 32'hD15);
    check("full_ready", {31'd0, mu_ready}, 32'd0);
    check("full_cnt", {30'd0, fifo_count}, 32'd2);
    cyc(1'b1, 1'b1, 5'd2, 32'hB4, 1'b0, 5'd0, 32'd0);
    cyc(1'b1, 1'b1, 5'd1, 32'hB5, 1'b0, 5'd0, 32'd0);
    check("bub_e", {31'd0, bubble_req}, 32'd0);
    cyc(1'b1, 1'b1, 5'd2, 32'hB6, 1'b0, 5'd0, 32'd0);
    check("bub_set", {31'd0, bubble_req}, 32'd1);
    idle();
    check("bub_hold", {31'd0, bubble_req}, 32'd1);
    check("bub_pop", {27'd0, WriteReg}, 32'd13);
    cyc(1'b1, 1'b1, 5'd6, 32'hB7, 1'b0, 5'd0, 32'd0);
    check("bub_clr", {31'd0, bubble_req}, 32'd0);
    idle();
    idle();

    // 5: hazard compare
    cyc(1'b1, 1'b1, 5'd2, 32'hC2, 1'b1, 5'd12, 32'hC12);
    rs = 5'd12;
    #1;
    check("haz_accept", {31'd0, hazard_stall}, 32'd1);
    cyc(1'b1, 1'b1, 5'd2, 32'hC3, 1'b1, 5'd0, 32'hDEAD);
    check("haz_entry", {31'd0, hazard_stall}, 32'd1);
    rs = 5'd0;
    #1;
    check("haz_r0", {31'd0, hazard_stall}, 32'd0);
    cyc(1'b1, 1'b1, 5'd2, 32'hC4, 1'b0, 5'd0, 32'd0);
    check("r0_discard", {30'd0, fifo_count}, 32'd1);
    rt = 5'd12;
    #1;
    check("haz_rt", {31'd0, hazard_stall}, 32'd1);
    rt = 5'd0;
    dest_sel = 5'd12;
    #1;
    check("haz_waw", {31'd0, hazard_stall}, 32'd1);
    dest_sel = 5'd0;
    rs = 5'd12;
    idle();
    check("haz_popcyc", {31'd0, hazard_stall}, 32'd1);
    idle();
    check("haz_clear", {31'd0, hazard_stall}, 32'd0);
    rs = 5'd0;

    // 6: reset discards pending entries
    cyc(1'b1, 1'b1, 5'd1, 32'hE1, 1'b1, 5'd16, 32'hF16);
    cyc(1'b1, 1'b1, 5'd1, 32'hE2, 1'b1, 5'd17, 32'hF17);
    cyc(1'b1, 1'b1, 5'd1, 32'hE3, 1'b0, 5'd0, 32'd0);
    check("pre_rst_cnt", {30'd0, fifo_count}, 32'd2);
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check("mid_rst_we", {31'd0, RegWrite}, 32'd0);
    idle();
    check("post_rst_cnt", {30'd0, fifo_count}, 32'd0);
    check("post_rst_we", {31'd0, RegWrite}, 32'd0);
    idle();
    idle();

    @(negedge clk);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/br_write_arbiter.md
Name: br_write_arbiter

Overview:
- Shares the single write port of the register bank `BR` between two requesters.
- Requester 1 is the pipeline writeback stage: fixed priority, never stalled.
- Requester 2 is a long-latency execution unit (mult/div): valid/ready handshake, writes buffered in a small FIFO.
- Sits between WB, the long-latency unit and `BR`. Also gives decode a hazard stall and gives the pipeline a bubble request against starvation.

Parameters:
- DEPTH, 2, number of FIFO entries for long-latency writes (power of two, ≥2).
- MAX_WAIT, 4, consecutive blocked cycles with FIFO non-empty before `bubble_req` asserts.
- DW, 32, data width.
- AW, 5, register address width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- wb_we  in  1  writeback write request.
- wb_addr  in  AW  writeback destination.
- wb_data  in  DW  writeback data.
- mu_valid  in  1  long-latency unit has a result.
- mu_ready  out  1  FIFO can accept this cycle.
- mu_addr  in  AW  long-latency destination.
- mu_data  in  DW  long-latency result.
- rs  in  AW  decode source 1.
- rt  in  AW  decode source 2.
- dest_sel  in  AW  decode destination.
- RegWrite  out  1  to BR `we`.
- WriteReg  out  AW  to BR `AW`.
- WriteData  out  DW  to BR `DW`.
- hazard_stall  out  1  decode must hold.
- bubble_req  out  1  pipeline must insert one WB-idle bubble.
- fifo_count  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (rst_n=0 at posedge):
  - FIFO emptied; wait counter set to 0.
  - While rst_n=0: RegWrite=0, mu_ready=0, hazard_stall=0, bubble_req=0; fifo_count=0 after the edge.
  - Reset mid-operation discards pending entries; no write reaches BR.
- Slot-busy: `wb_busy = wb_we && wb_addr != 0`.
- Write port (combinational):
  - wb_busy: RegWrite=1, WriteReg=wb_addr, WriteData=wb_data.
  - Else if fifo_count>0: RegWrite=1, head entry driven; head pops at the clock edge.
  - Else RegWrite=0; WriteReg/WriteData=0.
- mu_ready = rst_n && fifo_count<DEPTH.
- Handshake:
  - Accept on mu_valid && mu_ready.
  - mu_addr==0: accepted and discarded, no enqueue.
  - No bypass: an accepted write reaches BR at the earliest in the next cycle.
- Simultaneous push and pop: both happen; count unchanged.
- FIFO order is strict; indexes wrap modulo DEPTH.
- Wait counter:
  - Increments, saturating at MAX_WAIT, each cycle with fifo_count>0 && wb_busy.
  - Clears on any pop or when the FIFO is empty.
  - bubble_req = (wait_cnt==MAX_WAIT); held until a pop occurs.
- hazard_stall = 1 when a nonzero rs, rt or dest_sel equals the addr of either:
  - any valid FIFO entry, or
  - an entry being accepted this cycle.
  - This covers RAW and WAW against pending writes. Decode stalls until the entry is written, so WB and FIFO never race on one register.
- Register 0 never matches.

Decomposition:
- Shared package `br_pkg` holds:
  - AW/DW defaults.
  - Constant REG_ZERO=5'd0.
  - Struct/concat layout for a FIFO entry {addr, data}.
- One natural sub-module, `br_wfifo`: parameterised DEPTH synchronous FIFO with count, head outputs and per-entry addr taps for the comparator.
- Arbitration, wait counter and hazard compare stay in the top.

Test Plan:
1. Reset: hold rst_n=0 3 cycles with wb_we=1, mu_valid=1 -> RegWrite=0, mu_ready=0, fifo_count=0; release -> mu_ready=1.
2. Idle WB, mu write (addr=8, data=0xCAFE0001) -> mu_ready=1 at handshake; next cycle RegWrite=1, WriteReg=8, WriteData=0xCAFE0001; then fifo_count=0.
3. Conflict: FIFO holds addr 9; wb_we=1, wb_addr=3 -> port shows 3/WB data; wb_we=0 next -> port shows 9; order preserved for two entries 9 then 10.
4. Full and starvation: two pushes, wb_busy held -> mu_ready=0, fifo_count=2; after 4 blocked cycles bubble_req=1; wb_we=0 one cycle -> pop, bubble_req=0 next cycle.
5. Hazard: FIFO entry addr 12; rs=12 -> hazard_stall=1; rs=0 with entry addr 0 sent -> discarded, no stall, count unchanged; entry drains -> hazard_stall=0.
6. Reset mid-operation: FIFO count 2, assert rst_n=0 one cycle -> count 0, no RegWrite for those entries afterwards.
